// File: rtl/draw_circle_multi_if.sv
// ============================================================================
// Module : draw_circle_multi_if
// Brief  : VGA pixel-stream bundle (position, sync, blanking, colour).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

interface draw_circle_multi_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_circle_multi.sv
// ============================================================================
// Module : draw_circle_multi
// Brief  : 3-stage pipelined overlay of NUM_OBJ filled/ring circles with
//          fixed priority and vblank-synchronised double-buffered positions.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

module draw_circle_multi #(
  parameter int                    NUM_OBJ = 3,
  parameter int                    RADIUS  = 20,
  parameter int                    THICK   = 4,
  parameter logic [12*NUM_OBJ-1:0] COLORS  = {12'h00f, 12'h0ff, 12'hfff}
) (
  input  logic                    clk_in,
  input  logic                    rst,
  draw_circle_multi_if.slave      vga_in,
  draw_circle_multi_if.master     vga_out,
  input  logic [12*NUM_OBJ-1:0]   xpos_in,
  input  logic [12*NUM_OBJ-1:0]   ypos_in,
  input  logic [NUM_OBJ-1:0]      obj_en,
  input  logic [NUM_OBJ-1:0]      ring_mode,
  output logic [12*NUM_OBJ-1:0]   xpos_out,
  output logic [12*NUM_OBJ-1:0]   ypos_out,
  output logic                    frame_swap
);

  // Timing word layout: {hcount, vcount, hsync, hblnk, vsync, vblnk}
  localparam int          c_tw   = 28;
  localparam logic [26:0] c_r2   = 27'(RADIUS * RADIUS);
  localparam logic [26:0] c_in2  = 27'((RADIUS - THICK) * (RADIUS - THICK));

  logic                   r_vblnk_prev;
  logic                   r_frame_swap;
  logic                   w_swap;
  logic [12*NUM_OBJ-1:0]  r_xpos;
  logic [12*NUM_OBJ-1:0]  r_ypos;
  logic [NUM_OBJ-1:0]     r_en;
  logic [NUM_OBJ-1:0]     r_ring;

  logic [c_tw-1:0]        w_tim_in;
  logic [c_tw-1:0]        r_tim_s1;
  logic [c_tw-1:0]        r_tim_s2;
  logic [c_tw-1:0]        r_tim_s3;
  logic [11:0]            r_rgb_s1;
  logic [11:0]            r_rgb_s2;
  logic [11:0]            r_rgb_s3;
  logic [NUM_OBJ-1:0]     r_en_s1;
  logic [NUM_OBJ-1:0]     r_en_s2;
  logic [NUM_OBJ-1:0]     r_ring_s1;
  logic [NUM_OBJ-1:0]     r_ring_s2;
  logic [NUM_OBJ-1:0]     w_hit;
  logic [11:0]            w_color;
  logic                   w_any;
  logic                   w_blank_s2;

  assign w_tim_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync,
                     vga_in.hblnk, vga_in.vsync, vga_in.vblnk};
  assign w_swap   = vga_in.vblnk & ~r_vblnk_prev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_frame_swap <= 1'b0;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_en         <= '0;
      r_ring       <= '0;
    end else begin
      r_vblnk_prev <= vga_in.vblnk;
      r_frame_swap <= w_swap;
      if (w_swap) begin
        r_xpos <= xpos_in;
        r_ypos <= ypos_in;
        r_en   <= obj_en;
        r_ring <= ring_mode;
      end
    end
  end

  // Per-object enable/mode travel with the pixel so each pixel sees one shadow set
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tim_s1  <= '0;
      r_tim_s2  <= '0;
      r_tim_s3  <= '0;
      r_rgb_s1  <= '0;
      r_rgb_s2  <= '0;
      r_rgb_s3  <= '0;
      r_en_s1   <= '0;
      r_en_s2   <= '0;
      r_ring_s1 <= '0;
      r_ring_s2 <= '0;
    end else begin
      r_tim_s1  <= w_tim_in;
      r_tim_s2  <= r_tim_s1;
      r_tim_s3  <= r_tim_s2;
      r_rgb_s1  <= vga_in.rgb;
      r_rgb_s2  <= r_rgb_s1;
      r_rgb_s3  <= (w_blank_s2 || !w_any) ? r_rgb_s2 : w_color;
      r_en_s1   <= r_en;
      r_en_s2   <= r_en_s1;
      r_ring_s1 <= r_ring;
      r_ring_s2 <= r_ring_s1;
    end
  end

  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
    logic signed [12:0] w_dx;
    logic signed [12:0] w_dy;
    logic signed [12:0] r_dx;
    logic signed [12:0] r_dy;
    logic signed [25:0] w_dx_ext;
    logic signed [25:0] w_dy_ext;
    logic signed [25:0] w_sqx;
    logic signed [25:0] w_sqy;
    logic [26:0]        r_d2;

    // Zero-extend before subtracting so offsets stay signed without wrap
    assign w_dx     = $signed({1'b0, vga_in.hcount}) - $signed({1'b0, r_xpos[12*k +: 12]});
    assign w_dy     = $signed({1'b0, vga_in.vcount}) - $signed({1'b0, r_ypos[12*k +: 12]});
    assign w_dx_ext = 26'(r_dx);
    assign w_dy_ext = 26'(r_dy);
    assign w_sqx    = w_dx_ext * w_dx_ext;
    assign w_sqy    = w_dy_ext * w_dy_ext;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_dx <= '0;
        r_dy <= '0;
        r_d2 <= '0;
      end else begin
        r_dx <= w_dx;
        r_dy <= w_dy;
        r_d2 <= {1'b0, w_sqx} + {1'b0, w_sqy};
      end
    end

    assign w_hit[k] = r_en_s2[k] &&
                      (r_d2 <= c_r2) &&
                      (!r_ring_s2[k] || (r_d2 > c_in2));
  end

  always_comb begin
    w_color = '0;
    w_any   = 1'b0;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any   = 1'b1;
        w_color = COLORS[12*k +: 12];
      end
    end
  end

  assign w_blank_s2 = r_tim_s2[2] | r_tim_s2[0];

  assign vga_out.hcount = r_tim_s3[27:16];
  assign vga_out.vcount = r_tim_s3[15:4];
  assign vga_out.hsync  = r_tim_s3[3];
  assign vga_out.hblnk  = r_tim_s3[2];
  assign vga_out.vsync  = r_tim_s3[1];
  assign vga_out.vblnk  = r_tim_s3[0];
  assign vga_out.rgb    = r_rgb_s3;
  assign xpos_out       = r_xpos;
  assign ypos_out       = r_ypos;
  assign frame_swap     = r_frame_swap;

endmodule

`default_nettype wire

// File: tb/tb_draw_circle_multi.sv
// ============================================================================
// Module : tb_draw_circle_multi
// Brief  : Table-driven scoreboard bench for draw_circle_multi.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns / 1ps
`default_nettype none

module tb_draw_circle_multi;

  localparam logic [35:0] c_colors = {12'h00f, 12'h0ff, 12'hfff};

  logic        clk_in = 1'b0;
  logic        rst;
  logic [35:0] xpos_in, ypos_in, xpos_out, ypos_out;
  logic [2:0]  obj_en, ring_mode;
  logic        frame_swap;

  always #5 clk_in = ~clk_in;

  draw_circle_multi_if vin ();
  draw_circle_multi_if vout ();

  draw_circle_multi #(
    .NUM_OBJ (3),
    .RADIUS  (20),
    .THICK   (4),
    .COLORS  (c_colors)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .vga_in     (vin),
    .vga_out    (vout),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .obj_en     (obj_en),
    .ring_mode  (ring_mode),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .frame_swap (frame_swap)
  );

  typedef struct {
    logic        chk;
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] exp_rgb;
    int          id;
  } sb_t;

  typedef struct {
    int          cfg;
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    int          hit;
  } vec_t;

  sb_t  q[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   id_ctr = 0;

  function automatic logic [11:0] col(input int k);
    return c_colors[12*k +: 12];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One pixel per cycle; the entry pushed now is popped three edges later
  task automatic step(input logic [11:0] h, input logic [11:0] v, input logic hb,
                      input logic vb, input logic [11:0] rgb, input logic chk,
                      input logic [11:0] exp_rgb);
    sb_t e;
    @(negedge clk_in);
    vin.hcount = h;
    vin.vcount = v;
    vin.hsync  = h[0];
    vin.hblnk  = hb;
    vin.vsync  = v[0];
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    e.chk = chk; e.h = h; e.v = v; e.hb = hb; e.vb = vb; e.exp_rgb = exp_rgb;
    e.id  = id_ctr;
    id_ctr++;
    q.push_back(e);
    @(posedge clk_in);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      check($sformatf("pix%0d_timing", e.id),
            {vout.hcount, vout.vcount, vout.hsync, vout.hblnk, vout.vsync, vout.vblnk},
            {e.h, e.v, e.h[0], e.hb, e.v[0], e.vb});
      if (e.chk)
        check($sformatf("pix%0d_rgb", e.id), 128'(vout.rgb), 128'(e.exp_rgb));
    end
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic hb, input int hit);
    logic [11:0] rgb;
    rgb = 12'h400 + 12'(id_ctr);
    step(h, v, hb, 1'b0, rgb, 1'b1, (hit < 0) ? rgb : col(hit));
  endtask

  task automatic do_swap(input logic [35:0] x, input logic [35:0] y,
                         input logic [2:0] en, input logic [2:0] ring);
    xpos_in   = x;
    ypos_in   = y;
    obj_en    = en;
    ring_mode = ring;
    step(12'd0, 12'd600, 1'b1, 1'b1, 12'h0a5, 1'b1, 12'h0a5);
    check("swap_pulse", 128'(frame_swap), 128'd1);
    check("swap_shadow", {xpos_out, ypos_out}, {x, y});
    step(12'd1, 12'd600, 1'b1, 1'b1, 12'h0a6, 1'b1, 12'h0a6);
    check("swap_single", 128'(frame_swap), 128'd0);
    step(12'd2, 12'd0, 1'b1, 1'b0, 12'h0a7, 1'b1, 12'h0a7);
  endtask

  initial begin
    // cfg0: filled obj0 at (100,100)
    tbl.push_back('{0, 12'd120, 12'd100, 1'b0,  0});
    tbl.push_back('{0, 12'd112, 12'd116, 1'b0,  0});
    tbl.push_back('{0, 12'd121, 12'd100, 1'b0, -1});
    tbl.push_back('{0, 12'd114, 12'd115, 1'b0, -1});
    tbl.push_back('{0, 12'd100, 12'd100, 1'b0,  0});
    tbl.push_back('{0, 12'd100, 12'd100, 1'b1, -1});
    // cfg1: ring obj0 at (100,100)
    tbl.push_back('{1, 12'd100, 12'd100, 1'b0, -1});
    tbl.push_back('{1, 12'd116, 12'd100, 1'b0, -1});
    tbl.push_back('{1, 12'd117, 12'd100, 1'b0,  0});
    tbl.push_back('{1, 12'd120, 12'd100, 1'b0,  0});
    tbl.push_back('{1, 12'd121, 12'd100, 1'b0, -1});
    // cfg2/cfg3: obj0 and obj1 coincide, then obj0 disabled
    tbl.push_back('{2, 12'd200, 12'd200, 1'b0,  0});
    tbl.push_back('{2, 12'd215, 12'd200, 1'b0,  0});
    tbl.push_back('{3, 12'd200, 12'd200, 1'b0,  1});
    tbl.push_back('{3, 12'd221, 12'd200, 1'b0, -1});
    // cfg4: centre near the origin, negative offsets
    tbl.push_back('{4, 12'd0,    12'd0,    1'b0,  0});
    tbl.push_back('{4, 12'd4095, 12'd0,    1'b0, -1});
    tbl.push_back('{4, 12'd0,    12'd4095, 1'b0, -1});
    // cfg5: ring obj0 over filled obj2 at (50,50)
    tbl.push_back('{5, 12'd50, 12'd50, 1'b0,  2});
    tbl.push_back('{5, 12'd68, 12'd50, 1'b0,  0});
    tbl.push_back('{5, 12'd71, 12'd50, 1'b0, -1});

    rst        = 1'b1;
    vin.hcount = 12'd55;
    vin.vcount = 12'd66;
    vin.hsync  = 1'b1;
    vin.hblnk  = 1'b1;
    vin.vsync  = 1'b1;
    vin.vblnk  = 1'b1;
    vin.rgb    = 12'habc;
    xpos_in    = {3{12'd100}};
    ypos_in    = {3{12'd100}};
    obj_en     = 3'b111;
    ring_mode  = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in);
      #1;
      check($sformatf("reset_out%0d", i),
            {vout.hcount, vout.vcount, vout.hsync, vout.hblnk, vout.vsync,
             vout.vblnk, vout.rgb, frame_swap}, 128'd0);
      check($sformatf("reset_pos%0d", i), {xpos_out, ypos_out}, 128'd0);
    end
    rst = 1'b0;

    for (int c = 0; c <= 5; c++) begin
      case (c)
        0: do_swap({12'd0, 12'd0, 12'd100}, {12'd0, 12'd0, 12'd100}, 3'b001, 3'b000);
        1: do_swap({12'd0, 12'd0, 12'd100}, {12'd0, 12'd0, 12'd100}, 3'b001, 3'b001);
        2: do_swap({12'd0, 12'd200, 12'd200}, {12'd0, 12'd200, 12'd200}, 3'b011, 3'b000);
        3: do_swap({12'd0, 12'd200, 12'd200}, {12'd0, 12'd200, 12'd200}, 3'b010, 3'b000);
        4: do_swap({12'd0, 12'd0, 12'd10}, {12'd0, 12'd0, 12'd10}, 3'b001, 3'b000);
        default: do_swap({12'd50, 12'd0, 12'd50}, {12'd50, 12'd0, 12'd50}, 3'b101, 3'b001);
      endcase
      foreach (tbl[i])
        if (tbl[i].cfg == c) pix(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].hit);
    end

    // Mid-frame position change must wait for the next vblank start
    do_swap({12'd0, 12'd0, 12'd100}, {12'd0, 12'd0, 12'd60}, 3'b001, 3'b000);
    pix(12'd100, 12'd50, 1'b0, 0);
    xpos_in = {12'd0, 12'd0, 12'd300};
    pix(12'd100, 12'd60, 1'b0, 0);
    pix(12'd300, 12'd60, 1'b0, -1);
    pix(12'd110, 12'd61, 1'b0, 0);
    check("hold_xpos", 128'(xpos_out), 128'({12'd0, 12'd0, 12'd100}));
    check("hold_noswap", 128'(frame_swap), 128'd0);
    do_swap({12'd0, 12'd0, 12'd300}, {12'd0, 12'd0, 12'd60}, 3'b001, 3'b000);
    pix(12'd300, 12'd60, 1'b0, 0);
    pix(12'd100, 12'd60, 1'b0, -1);

    // Reset in the middle of active video
    pix(12'd300, 12'd61, 1'b0, 0);
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    check("midrst_out", {vout.hcount, vout.vcount, vout.rgb, frame_swap, xpos_out}, 128'd0);
    q.delete();
    rst = 1'b0;
    pix(12'd300, 12'd60, 1'b0, -1);
    check("midrst_flush", {vout.hcount, vout.rgb}, 128'd0);
    pix(12'd301, 12'd60, 1'b0, -1);
    pix(12'd302, 12'd60, 1'b0, -1);
    pix(12'd303, 12'd60, 1'b0, -1);
    for (int i = 0; i < 3; i++)
      step(12'(700 + i), 12'd60, 1'b1, 1'b0, 12'h0b0, 1'b1, 12'h0b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
